sequence_generator: RTL and testbench

//   Serial pattern transmitter: the drive side of the FSM serial-bit interface

---
 rtl/sequence_generator.sv | 125 ++++++++++++
 tb/tb_sequence_generator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first,
// repeated reps times with an optional idle gap between repeats.
module sequence_generator #(
  parameter int PAT_W   = 4,
  parameter int GAP_CYC = 0,
  parameter int REP_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             data,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(PAT_W);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [IW-1:0]    IDX_LAST = IW'(PAT_W - 1);
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [PAT_W-1:0] pat;
  logic [REP_W-1:0] rep_cnt;
  logic [IW-1:0]    bit_idx;
  logic [GW-1:0]    gap_cnt;

  // Outputs are loaded on the same edge as the state they belong to,
  // so the first bit appears in the cycle right after start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat     <= '0;
      rep_cnt <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      data    <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pat     <= pattern;
            rep_cnt <= reps;
            bit_idx <= IDX_LAST;
            if (reps != '0) begin
              state <= SHIFT;
              data  <= pattern[PAT_W-1];
              valid <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            data  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (bit_idx != '0) begin
            bit_idx <= bit_idx - IDX_ONE;
            data    <= pat[bit_idx - IDX_ONE];
          end else begin
            rep_cnt <= (rep_cnt != '0) ? rep_cnt - REP_ONE : rep_cnt;
            if (rep_cnt > REP_ONE) begin
              if (GAP_CYC > 0) begin
                state   <= GAP;
                gap_cnt <= GAP_LAST;
                data    <= 1'b0;
                valid   <= 1'b0;
              end else begin
                bit_idx <= IDX_LAST;
                data    <= pat[PAT_W-1];
              end
            end else begin
              state <= DONE;
              data  <= 1'b0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
            data  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            state   <= SHIFT;
            bit_idx <= IDX_LAST;
            data    <= pat[PAT_W-1];
            valid   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench: two generators (no gap / two-cycle gap) share clock and reset.
module tb_sequence_generator;

  typedef struct packed {
    logic data;
    logic valid;
    logic busy;
    logic done;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       start0, abort0, start2, abort2;
  logic [3:0] pattern0, pattern2;
  logic [7:0] reps0, reps2;
  logic       data0, valid0, busy0, done0;
  logic       data2, valid2, busy2, done2;

  rec_t q0[$];
  rec_t q2[$];
  rec_t e0, e2;
  int   checks   = 0;
  int   failures = 0;

  sequence_generator #(.PAT_W(4), .GAP_CYC(0), .REP_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .pattern(pattern0), .reps(reps0),
    .data(data0), .valid(valid0), .busy(busy0), .done(done0)
  );

  sequence_generator #(.PAT_W(4), .GAP_CYC(2), .REP_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .pattern(pattern2), .reps(reps2),
    .data(data2), .valid(valid2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got {data,valid,busy,done}=%b expected %b", nm, $time, got, exp);
    end
  endtask

  // Empty queue means the line must be idle.
  always @(negedge clk) begin
    e0 = (q0.size() > 0) ? q0.pop_front() : rec_t'(4'b0000);
    check("dut0", {data0, valid0, busy0, done0}, e0);
    e2 = (q2.size() > 0) ? q2.pop_front() : rec_t'(4'b0000);
    check("dut2", {data2, valid2, busy2, done2}, e2);
  end

  task automatic push(input int sel, input rec_t r);
    if (sel == 0) q0.push_back(r);
    else          q2.push_back(r);
  endtask

  task automatic push_burst(input int sel, input logic [3:0] p, input int n, input int gap);
    rec_t r;
    r = '0;
    push(sel, r);
    for (int k = 0; k < n; k++) begin
      for (int b = 3; b >= 0; b--) begin
        r.data = p[b]; r.valid = 1'b1; r.busy = 1'b1; r.done = 1'b0;
        push(sel, r);
      end
      if (k < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          r = 4'b0010;
          push(sel, r);
        end
      end
    end
    r = 4'b0001;
    push(sel, r);
  endtask

  task automatic push_bits(input int sel, input logic [3:0] p, input int cnt);
    rec_t r;
    r = '0;
    push(sel, r);
    for (int i = 0; i < cnt; i++) begin
      r.data = p[3 - (i % 4)]; r.valid = 1'b1; r.busy = 1'b1; r.done = 1'b0;
      push(sel, r);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input int sel, input logic [3:0] p, input int n);
    if (sel == 0) begin
      start0 = 1'b1; pattern0 = p; reps0 = 8'(n);
      push_burst(0, p, n, 0);
      step();
      start0 = 1'b0;
    end else begin
      start2 = 1'b1; pattern2 = p; reps2 = 8'(n);
      push_burst(2, p, n, 2);
      step();
      start2 = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((q0.size() != 0 || q2.size() != 0) && n < 3000);
    if (q0.size() != 0 || q2.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending q0=%0d q2=%0d required 0", q0.size(), q2.size());
      q0.delete();
      q2.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    start0 = 1'b1; abort0 = 1'b0; pattern0 = 4'b1010; reps0 = 8'd2;
    start2 = 1'b1; abort2 = 1'b0; pattern2 = 4'b1100; reps2 = 8'd2;

    // 1) reset held with start asserted
    #50;
    step();
    start0 = 1'b0; start2 = 1'b0;
    step();
    rst = 1'b1;
    repeat (4) step();

    // 2) back-to-back repeats
    fire(0, 4'b1010, 2);
    wait_drain();

    // 3) gapped repeats
    fire(2, 4'b1100, 2);
    wait_drain();
    fire(2, 4'b1001, 3);
    wait_drain();

    // 4) zero repeats: done only
    fire(0, 4'b1111, 0);
    wait_drain();

    // 5) mid-burst start/pattern change ignored, then abort
    start0 = 1'b1; pattern0 = 4'b1010; reps0 = 8'd2;
    push_bits(0, 4'b1010, 5);
    step();
    start0 = 1'b0;
    step();
    step();
    start0 = 1'b1; pattern0 = 4'b0111;
    step();
    start0 = 1'b0;
    step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    wait_drain();
    fire(0, 4'b0110, 1);
    wait_drain();

    // abort during a gap
    start2 = 1'b1; pattern2 = 4'b1100; reps2 = 8'd3;
    push_bits(2, 4'b1100, 4);
    push(2, rec_t'(4'b0010));
    step();
    start2 = 1'b0;
    repeat (4) step();
    abort2 = 1'b1;
    step();
    abort2 = 1'b0;
    wait_drain();

    // start in DONE ignored
    fire(0, 4'b1111, 1);
    repeat (4) step();
    start0 = 1'b1; pattern0 = 4'b1011; reps0 = 8'd1;
    step();
    start0 = 1'b0;
    wait_drain();

    // abort in IDLE blocks start
    start0 = 1'b1; abort0 = 1'b1; pattern0 = 4'b1111; reps0 = 8'd1;
    step();
    start0 = 1'b0; abort0 = 1'b0;
    repeat (3) step();

    // 6) asynchronous reset mid-burst, then full replay
    start0 = 1'b1; pattern0 = 4'b1010; reps0 = 8'd2;
    push_bits(0, 4'b1010, 2);
    step();
    start0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_async", {data0, valid0, busy0, done0}, 4'b0000);
    step();
    step();
    rst = 1'b1;
    step();
    fire(0, 4'b1010, 2);
    wait_drain();

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
